// File: rtl/scr1_pipe_lsu_hs_arb.sv
// Two-requester highspeed LSU arbiter: core LSU (0) and DLA engine (1) share one dmem port.
// Latency: grant/ack are combinational in IDLE; response is routed combinationally in BUSY; one bubble after each response.
// Backpressure: a requester holds req and fields until ack; one transaction is outstanding at a time.
// Optional macro SCR1_HS_ARB_TIMEOUT_EN adds a response timeout of TMO_CYCLES busy cycles.

`ifndef YTYDLA_LSU_WIDTH
`define YTYDLA_LSU_WIDTH 128
`endif

package scr1_hs_arb_pkg;
  localparam int unsigned SCR1_DMEM_AWIDTH = 32;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [2:0] {
    SCR1_MEM_Y_WIDTH_ONE   = 3'd1,
    SCR1_MEM_Y_WIDTH_TWO   = 3'd2,
    SCR1_MEM_Y_WIDTH_THREE = 3'd3,
    SCR1_MEM_Y_WIDTH_FOUR  = 3'd4,
    SCR1_MEM_Y_WIDTH_FIVE  = 3'd5
  } type_scr1_mem_y_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_IDLE   = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;
endpackage

module scr1_pipe_lsu_hs_arb
  import scr1_hs_arb_pkg::*;
#(
  parameter int unsigned HS_WIDTH   = `YTYDLA_LSU_WIDTH,
  parameter int unsigned TMO_CYCLES = 255
) (
  input  logic                          clk,
  input  logic                          rst,
  // requester 0: core highspeed LSU
  input  logic                          req0,
  input  type_scr1_mem_cmd_e            cmd0,
  input  type_scr1_mem_y_width_e        width0,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   addr0,
  input  logic [HS_WIDTH-1:0]           wdata0,
  output logic                          ack0,
  output logic [HS_WIDTH-1:0]           rdata0,
  output type_scr1_mem_resp_e           resp0,
  // requester 1: DLA engine
  input  logic                          req1,
  input  type_scr1_mem_cmd_e            cmd1,
  input  type_scr1_mem_y_width_e        width1,
  input  logic [SCR1_DMEM_AWIDTH-1:0]   addr1,
  input  logic [HS_WIDTH-1:0]           wdata1,
  output logic                          ack1,
  output logic [HS_WIDTH-1:0]           rdata1,
  output type_scr1_mem_resp_e           resp1,
  // downstream data memory
  output logic                          dmem_req,
  output type_scr1_mem_cmd_e            dmem_cmd,
  output type_scr1_mem_y_width_e        dmem_width,
  output logic [SCR1_DMEM_AWIDTH-1:0]   dmem_addr,
  output logic [HS_WIDTH-1:0]           dmem_wdata,
  input  logic                          dmem_req_ack,
  input  logic [HS_WIDTH-1:0]           dmem_rdata,
  input  type_scr1_mem_resp_e           dmem_resp,
  output logic                          busy
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  localparam logic [9:0] TMO_LAST = 10'(TMO_CYCLES - 1);

  state_e state;
  state_e state_nxt;
  logic   last_owner;   // also the current owner while BUSY, since it is latched on ack
  logic   gnt;          // 0: requester 0, 1: requester 1
  logic   hs_ack;
  logic   resp_vld;
  logic   tmo_hit;
  logic   done;

  assign busy     = (state == ST_BUSY);
  assign dmem_req = (req0 | req1) & (state == ST_IDLE);
  assign hs_ack   = dmem_req & dmem_req_ack;
  assign resp_vld = busy & ((dmem_resp == SCR1_MEM_RESP_RDY_OK) |
                            (dmem_resp == SCR1_MEM_RESP_RDY_ER));
  assign done     = resp_vld | tmo_hit;

`ifdef SCR1_HS_ARB_TIMEOUT_EN
  logic [9:0] tmo_cnt;

  // Busy-cycle counter, restarted at each accepted request
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
    end else if (hs_ack) begin
      tmo_cnt <= '0;
    end else if (busy) begin
      tmo_cnt <= tmo_cnt + 10'd1;
    end
  end

  // A real response in the expiry cycle wins over the timeout error
  assign tmo_hit = busy & (tmo_cnt == TMO_LAST) & ~resp_vld;
`else
  logic tmo_unused;
  assign tmo_unused = ^TMO_LAST;
  assign tmo_hit    = 1'b0;
`endif

  // Round-robin grant: a lone requester wins, a tie goes to the one that did not own last
  always_comb begin
    gnt = 1'b0;
    if (req0 & req1) begin
      gnt = ~last_owner;
    end else if (req1) begin
      gnt = 1'b1;
    end
  end

  // Request fields follow the grant; requester 0 fields when nobody requests
  assign dmem_cmd   = gnt ? cmd1   : cmd0;
  assign dmem_width = gnt ? width1 : width0;
  assign dmem_addr  = gnt ? addr1  : addr0;
  assign dmem_wdata = gnt ? wdata1 : wdata0;

  // State register and owner tracking
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      last_owner <= 1'b1;
    end else begin
      state <= state_nxt;
      if (hs_ack) begin
        last_owner <= gnt;
      end
    end
  end

  // Next state: leave IDLE on acceptance, leave BUSY on response or timeout
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hs_ack) state_nxt = ST_BUSY;
      ST_BUSY: if (done)   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs: acks to the granted requester, responses only to the owner while BUSY
  always_comb begin
    ack0   = 1'b0;
    ack1   = 1'b0;
    resp0  = SCR1_MEM_RESP_IDLE;
    resp1  = SCR1_MEM_RESP_IDLE;
    rdata0 = '0;
    rdata1 = '0;
    if (hs_ack) begin
      ack0 = ~gnt;
      ack1 = gnt;
    end
    if (resp_vld) begin
      if (last_owner) begin
        resp1  = dmem_resp;
        rdata1 = dmem_rdata;
      end else begin
        resp0  = dmem_resp;
        rdata0 = dmem_rdata;
      end
    end else if (tmo_hit) begin
      if (last_owner) begin
        resp1 = SCR1_MEM_RESP_RDY_ER;
      end else begin
        resp0 = SCR1_MEM_RESP_RDY_ER;
      end
    end
  end

endmodule

// File: tb/tb_scr1_pipe_lsu_hs_arb.sv
// Directed bench for scr1_pipe_lsu_hs_arb: reset, single read, contention, withdraw, error, reset in busy, timeout.
// Inputs change 1 time unit after the rising edge; outputs are compared 2 units later, mid-cycle.
// Define SCR1_HS_ARB_TIMEOUT_EN to also exercise the timeout path with TMO_CYCLES=4.
module tb_scr1_pipe_lsu_hs_arb;
  import scr1_hs_arb_pkg::*;

  localparam int unsigned HS_W = 128;

  logic                        clk;
  logic                        rst;
  logic                        req0, req1;
  type_scr1_mem_cmd_e          cmd0, cmd1;
  type_scr1_mem_y_width_e      width0, width1;
  logic [SCR1_DMEM_AWIDTH-1:0] addr0, addr1;
  logic [HS_W-1:0]             wdata0, wdata1;
  logic                        ack0, ack1;
  logic [HS_W-1:0]             rdata0, rdata1;
  type_scr1_mem_resp_e         resp0, resp1;
  logic                        dmem_req;
  type_scr1_mem_cmd_e          dmem_cmd;
  type_scr1_mem_y_width_e      dmem_width;
  logic [SCR1_DMEM_AWIDTH-1:0] dmem_addr;
  logic [HS_W-1:0]             dmem_wdata;
  logic                        dmem_req_ack;
  logic [HS_W-1:0]             dmem_rdata;
  type_scr1_mem_resp_e         dmem_resp;
  logic                        busy;

  int  n_vec = 0;
  int  n_err = 0;
  logic gexp;

  scr1_pipe_lsu_hs_arb #(.HS_WIDTH(HS_W), .TMO_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .cmd0(cmd0), .width0(width0), .addr0(addr0), .wdata0(wdata0),
    .ack0(ack0), .rdata0(rdata0), .resp0(resp0),
    .req1(req1), .cmd1(cmd1), .width1(width1), .addr1(addr1), .wdata1(wdata1),
    .ack1(ack1), .rdata1(rdata1), .resp1(resp1),
    .dmem_req(dmem_req), .dmem_cmd(dmem_cmd), .dmem_width(dmem_width),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_req_ack(dmem_req_ack),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [HS_W-1:0] obs, input logic [HS_W-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    req0 = 1'b0; req1 = 1'b0;
    cmd0 = SCR1_MEM_CMD_RD; cmd1 = SCR1_MEM_CMD_WR;
    width0 = SCR1_MEM_Y_WIDTH_ONE; width1 = SCR1_MEM_Y_WIDTH_TWO;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    dmem_req_ack = 1'b0; dmem_rdata = '0; dmem_resp = SCR1_MEM_RESP_IDLE;

    // reset state
    #3;
    chk("rst_busy", busy, 0);
    chk("rst_dmem_req", dmem_req, 0);
    chk("rst_ack0", ack0, 0);
    chk("rst_resp0", resp0, SCR1_MEM_RESP_IDLE);
    chk("rst_rdata1", rdata1, 0);
    req0 = 1'b1; #1;
    chk("rst_dmem_req_comb", dmem_req, 1);
    req0 = 1'b0;
    cyc(); cyc();
    rst = 1'b0;

    // stray response in IDLE is discarded
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 128'hdead; #2;
    chk("idle_resp0", resp0, SCR1_MEM_RESP_IDLE);
    chk("idle_resp1", resp1, SCR1_MEM_RESP_IDLE);
    chk("idle_rdata0", rdata0, 0);
    cyc();
    dmem_resp = SCR1_MEM_RESP_IDLE;

    // single read: ack at cycle 0, response at cycle 3
    req0 = 1'b1; cmd0 = SCR1_MEM_CMD_RD; width0 = SCR1_MEM_Y_WIDTH_FIVE; addr0 = 32'h100;
    dmem_req_ack = 1'b1; #2;
    chk("rd_ack0", ack0, 1);
    chk("rd_ack1", ack1, 0);
    chk("rd_addr", dmem_addr, 32'h100);
    chk("rd_width", dmem_width, SCR1_MEM_Y_WIDTH_FIVE);
    chk("rd_cmd", dmem_cmd, SCR1_MEM_CMD_RD);
    chk("rd_busy0", busy, 0);
    cyc();
    req0 = 1'b0; dmem_req_ack = 1'b0; #2;
    chk("rd_busy1", busy, 1);
    chk("rd_dreq1", dmem_req, 0);
    chk("rd_resp0_c1", resp0, SCR1_MEM_RESP_IDLE);
    cyc(); #2;
    chk("rd_busy2", busy, 1);
    cyc();
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 128'h1234_5678_9abc; #2;
    chk("rd_busy3", busy, 1);
    chk("rd_resp0", resp0, SCR1_MEM_RESP_RDY_OK);
    chk("rd_rdata0", rdata0, 128'h1234_5678_9abc);
    chk("rd_resp1", resp1, SCR1_MEM_RESP_IDLE);
    chk("rd_rdata1", rdata1, 0);
    cyc();
    dmem_resp = SCR1_MEM_RESP_IDLE; #2;
    chk("rd_busy4", busy, 0);

    // contention after a fresh reset: grants 0,1,0,1, acks 3 cycles apart
    rst = 1'b1; cyc(); rst = 1'b0;
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h200; addr1 = 32'h300;
    cmd0 = SCR1_MEM_CMD_RD; cmd1 = SCR1_MEM_CMD_WR;
    wdata0 = 128'haaaa; wdata1 = 128'hbbbb; dmem_req_ack = 1'b1;
    for (int g = 0; g < 4; g++) begin
      gexp = (g % 2 == 1);
      #2;
      chk("ct_ack0", ack0, !gexp);
      chk("ct_ack1", ack1, gexp);
      chk("ct_addr", dmem_addr, gexp ? 32'h300 : 32'h200);
      chk("ct_wdata", dmem_wdata, gexp ? 128'hbbbb : 128'haaaa);
      chk("ct_cmd", dmem_cmd, gexp ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD);
      cyc(); #2;
      chk("ct_dreq_busy", dmem_req, 0);
      chk("ct_acks_busy", ack0 | ack1, 0);
      cyc();
      dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = HS_W'(g + 1); #2;
      chk("ct_resp0", resp0, gexp ? SCR1_MEM_RESP_IDLE : SCR1_MEM_RESP_RDY_OK);
      chk("ct_resp1", resp1, gexp ? SCR1_MEM_RESP_RDY_OK : SCR1_MEM_RESP_IDLE);
      chk("ct_rdata", gexp ? rdata1 : rdata0, HS_W'(g + 1));
      cyc();
      dmem_resp = SCR1_MEM_RESP_IDLE;
    end
    req0 = 1'b0; req1 = 1'b0; dmem_req_ack = 1'b0;

    // withdraw: req1 waits unacked two cycles, then drops as req0 rises
    req1 = 1'b1; addr1 = 32'h300;
    for (int i = 0; i < 2; i++) begin
      #2;
      chk("wd_addr1", dmem_addr, 32'h300);
      chk("wd_ack1", ack1, 0);
      cyc();
    end
    req1 = 1'b0; req0 = 1'b1; addr0 = 32'h200; #2;
    chk("wd_addr0", dmem_addr, 32'h200);
    chk("wd_dreq", dmem_req, 1);
    chk("wd_ack1b", ack1, 0);
    cyc();
    dmem_req_ack = 1'b1; #2;
    chk("wd_ack0", ack0, 1);
    chk("wd_ack1c", ack1, 0);
    cyc();
    req0 = 1'b0; dmem_req_ack = 1'b0; dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 128'h9; #2;
    chk("wd_resp0", resp0, SCR1_MEM_RESP_RDY_OK);
    cyc();
    dmem_resp = SCR1_MEM_RESP_IDLE;

    // error response to owner 1
    req1 = 1'b1; addr1 = 32'h340; dmem_req_ack = 1'b1; #2;
    chk("er_ack1", ack1, 1);
    cyc();
    req1 = 1'b0; dmem_req_ack = 1'b0; dmem_resp = SCR1_MEM_RESP_RDY_ER; dmem_rdata = 128'h55; #2;
    chk("er_resp1", resp1, SCR1_MEM_RESP_RDY_ER);
    chk("er_resp0", resp0, SCR1_MEM_RESP_IDLE);
    chk("er_rdata1", rdata1, 128'h55);
    chk("er_rdata0", rdata0, 0);
    cyc();
    dmem_resp = SCR1_MEM_RESP_IDLE; #2;
    chk("er_idle", busy, 0);

    // reset while busy: owner 0 in flight, response after reset is dropped
    req0 = 1'b1; addr0 = 32'h400; dmem_req_ack = 1'b1; #2;
    chk("rb_ack0", ack0, 1);
    cyc();
    req0 = 1'b0; dmem_req_ack = 1'b0; #2;
    chk("rb_busy", busy, 1);
    rst = 1'b1; #1;
    chk("rb_busy_rst", busy, 0);
    cyc();
    rst = 1'b0;
    dmem_resp = SCR1_MEM_RESP_RDY_OK; dmem_rdata = 128'h77; #2;
    chk("rb_resp0", resp0, SCR1_MEM_RESP_IDLE);
    chk("rb_resp1", resp1, SCR1_MEM_RESP_IDLE);
    chk("rb_rdata0", rdata0, 0);
    cyc();
    dmem_resp = SCR1_MEM_RESP_IDLE;
    req0 = 1'b1; req1 = 1'b1; addr0 = 32'h500; addr1 = 32'h600; #2;
    chk("rb_tie_addr", dmem_addr, 32'h500);
    chk("rb_busy_after", busy, 0);
    cyc();
    req0 = 1'b0; req1 = 1'b0;

`ifdef SCR1_HS_ARB_TIMEOUT_EN
    // timeout after 4 busy cycles, later stray response ignored
    req0 = 1'b1; dmem_req_ack = 1'b1; #2;
    chk("to_ack0", ack0, 1);
    cyc();
    req0 = 1'b0; dmem_req_ack = 1'b0; dmem_rdata = 128'haa;
    for (int i = 1; i <= 4; i++) begin
      #2;
      chk("to_busy", busy, 1);
      chk("to_resp0", resp0, (i == 4) ? SCR1_MEM_RESP_RDY_ER : SCR1_MEM_RESP_IDLE);
      if (i == 4) chk("to_rdata0", rdata0, 0);
      cyc();
    end
    dmem_resp = SCR1_MEM_RESP_RDY_OK; #2;
    chk("to_stray", resp0, SCR1_MEM_RESP_IDLE);
    chk("to_idle", busy, 0);
    cyc();
    dmem_resp = SCR1_MEM_RESP_IDLE;

    // response in the expiry cycle wins
    req0 = 1'b1; dmem_req_ack = 1'b1; #2;
    chk("tp_ack0", ack0, 1);
    cyc();
    req0 = 1'b0; dmem_req_ack = 1'b0;
    cyc(); cyc(); cyc();
    dmem_resp = SCR1_MEM_RESP_RDY_OK; #2;
    chk("tp_resp0", resp0, SCR1_MEM_RESP_RDY_OK);
    chk("tp_rdata0", rdata0, 128'haa);
    cyc();
    dmem_resp = SCR1_MEM_RESP_IDLE; #2;
    chk("tp_idle", busy, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
